// File: rtl/mdio_pkg.sv
// Clause-22 MDIO constants, PHY register map and poller state encoding.
// Shared by the link poller and any future MDIO master.
// No logic of its own; pure definitions.
package mdio_pkg;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam int         PREAMBLE_BITS = 32;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;

    localparam int BMSR_LINK      = 2;
    localparam int BMSR_ANEG_DONE = 5;

    // Bit positions inside the 64-bit read frame.
    localparam logic [5:0] HDR_FIRST   = 6'(PREAMBLE_BITS);
    localparam logic [5:0] TA_FIRST    = 6'd46;
    localparam logic [5:0] TA_LAST     = 6'd47;
    localparam logic [5:0] DATA_FIRST  = 6'd48;
    localparam logic [5:0] FRAME_LAST  = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE,
        S_WAIT
    } state_t;

    // Frame phase that owns a given bit position.
    function automatic state_t bit_state(input logic [5:0] b);
        if (b < HDR_FIRST)       return S_PRE;
        else if (b < TA_FIRST)   return S_HDR;
        else if (b < DATA_FIRST) return S_TA;
        else                     return S_DATA;
    endfunction

endpackage

// File: rtl/mdio_link_poller_if.sv
// MDIO pad bundle: clock, driven data, output enable and synchronised input.
// Master owns mdc/mdio_o/mdio_oe; the PHY side returns mdio_i.
// No handshake; timing is set entirely by the master's mdc.
interface mdio_link_poller_if;
    logic mdc;
    logic mdio_o;
    logic mdio_oe;
    logic mdio_i;

    modport master (output mdc, output mdio_o, output mdio_oe, input mdio_i);
    modport slave  (input mdc, input mdio_o, input mdio_oe, output mdio_i);
endinterface

// File: rtl/mdio_bit_timer.sv
// MDC generator: each bit is 2*CLK_DIV clocks, mdc low for the first half.
// sample_o marks the clock whose edge raises mdc; bit_start_o marks the clock
// whose edge begins the next bit. Dropping run_i parks mdc low at phase 0.
module mdio_bit_timer #(
    parameter int CLK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    output logic mdc_o,
    output logic sample_o,
    output logic bit_start_o
);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

    logic [PW-1:0] ph_q, ph_d;
    logic          mdc_q, mdc_d;

    // Phase counter and mdc level for the next clock.
    always_comb begin
        ph_d  = ph_q;
        mdc_d = mdc_q;
        if (!run_i) begin
            ph_d  = '0;
            mdc_d = 1'b0;
        end else begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
            if (ph_q == PH_RISE)      mdc_d = 1'b1;
            else if (ph_q == PH_LAST) mdc_d = 1'b0;
        end
    end

    // Phase and mdc registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ph_q  <= '0;
            mdc_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_o       = mdc_q;
    assign sample_o    = run_i && (ph_q == PH_RISE);
    assign bit_start_o = run_i && (ph_q == PH_LAST);
endmodule

// File: rtl/mdio_link_poller.sv
// Periodic clause-22 read of a PHY register while phy_init_done is high.
// One 64-bit frame is 128*CLK_DIV clocks; results publish in the DONE clock.
// No backpressure: status pulses are one clock wide and not held.
module mdio_link_poller
    import mdio_pkg::*;
#(
    parameter int         CLK_DIV       = 10,
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter logic [4:0] REG_ADDR      = 5'd1,
    parameter int         POLL_INTERVAL = 2500000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       phy_init_done,
    mdio_link_poller_if.master         mdio,
    output logic [15:0]                status_reg,
    output logic                       status_valid,
    output logic                       link_up,
    output logic                       autoneg_done,
    output logic                       read_error,
    output logic                       busy
);
    localparam int WW = $clog2(POLL_INTERVAL + 1);
    // DONE counts as the first clock of the interval, so WAIT ends one early.
    localparam logic [WW-1:0] WAIT_LAST = WW'(POLL_INTERVAL - 1);
    localparam logic [45:0]   HDR_SEQ   = {32'hFFFF_FFFF, ST, OP_READ, PHY_ADDR, REG_ADDR};

    state_t        state_q, state_d;
    logic [5:0]    bit_q, bit_d, bit_nx;
    logic [WW-1:0] wait_q, wait_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   status_q, status_d;
    logic          ta_bad_q, ta_bad_d;
    logic          mdio_o_q, mdio_o_d;
    logic          mdio_oe_q, mdio_oe_d;
    logic          valid_q, valid_d;
    logic          link_q, link_d;
    logic          aneg_q, aneg_d;
    logic          rerr_q, rerr_d;
    logic          busy_w, run_w, sample_w, bit_start_w, mdc_w;

    assign busy_w = (state_q == S_PRE) || (state_q == S_HDR) ||
                    (state_q == S_TA)  || (state_q == S_DATA);
    assign run_w  = busy_w && phy_init_done;
    assign bit_nx = bit_q + 6'd1;

    mdio_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .run_i       (run_w),
        .mdc_o       (mdc_w),
        .sample_o    (sample_w),
        .bit_start_o (bit_start_w)
    );

    // Frame sequencing, pad drive for the upcoming bit, and result publication.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        wait_d    = wait_q;
        shift_d   = shift_q;
        status_d  = status_q;
        ta_bad_d  = ta_bad_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        link_d    = link_q;
        aneg_d    = aneg_q;
        valid_d   = 1'b0;
        rerr_d    = 1'b0;
        if (!phy_init_done) begin
            // Link knowledge is stale once the PHY is re-initialising.
            state_d   = S_IDLE;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            link_d    = 1'b0;
            aneg_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_WAIT: begin
                    if (state_q == S_IDLE || wait_q >= WAIT_LAST) begin
                        state_d   = S_PRE;
                        bit_d     = '0;
                        ta_bad_d  = 1'b0;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_PRE, S_HDR, S_TA, S_DATA: begin
                    if (sample_w) begin
                        if (bit_q == TA_LAST)    ta_bad_d = mdio.mdio_i;
                        else if (state_q == S_DATA) shift_d = {shift_q[14:0], mdio.mdio_i};
                    end
                    if (bit_start_w) begin
                        if (bit_q == FRAME_LAST) begin
                            state_d   = S_DONE;
                            mdio_oe_d = 1'b0;
                            mdio_o_d  = 1'b1;
                            if (ta_bad_q) begin
                                rerr_d = 1'b1;
                            end else begin
                                status_d = shift_q;
                                valid_d  = 1'b1;
                                link_d   = shift_q[BMSR_LINK];
                                aneg_d   = shift_q[BMSR_ANEG_DONE];
                            end
                        end else begin
                            bit_d     = bit_nx;
                            state_d   = bit_state(bit_nx);
                            mdio_oe_d = (bit_nx < TA_FIRST);
                            mdio_o_d  = (bit_nx < TA_FIRST) ? HDR_SEQ[6'd45 - bit_nx] : 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_WAIT;
                    wait_d  = WW'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            wait_q    <= '0;
            shift_q   <= '0;
            status_q  <= '0;
            ta_bad_q  <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            valid_q   <= 1'b0;
            link_q    <= 1'b0;
            aneg_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            wait_q    <= wait_d;
            shift_q   <= shift_d;
            status_q  <= status_d;
            ta_bad_q  <= ta_bad_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            valid_q   <= valid_d;
            link_q    <= link_d;
            aneg_q    <= aneg_d;
            rerr_q    <= rerr_d;
        end
    end

    assign mdio.mdc     = mdc_w;
    assign mdio.mdio_o  = mdio_o_q;
    assign mdio.mdio_oe = mdio_oe_q;
    assign status_reg   = status_q;
    assign status_valid = valid_q;
    assign link_up      = link_q;
    assign autoneg_done = aneg_q;
    assign read_error   = rerr_q;
    assign busy         = busy_w;
endmodule

// File: tb/tb_mdio_link_poller.sv
// Bench for mdio_link_poller: cycle-level PHY model plus pad/status monitor.
module tb_mdio_link_poller;
    import mdio_pkg::*;

    localparam int D          = 2;
    localparam int P          = 100;
    localparam int FRAME_CLKS = 128 * D;
    localparam int BUDGET     = FRAME_CLKS + P + 40;
    localparam logic [45:0] EXP_HDR  = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd1};
    localparam logic [63:0] EXP_OE   = {{46{1'b1}}, 18'd0};
    localparam logic [23:0] RST_OUTS = {1'b0, 1'b1, 1'b0, 16'h0, 5'b0};

    logic        clock, reset, phy_init_done;
    logic [15:0] status_reg;
    logic        status_valid, link_up, autoneg_done, read_error, busy;

    mdio_link_poller_if mdio_bus();

    mdio_link_poller #(
        .CLK_DIV(D), .PHY_ADDR(5'd0), .REG_ADDR(5'd1), .POLL_INTERVAL(P)
    ) dut (
        .clock(clock), .reset(reset), .phy_init_done(phy_init_done),
        .mdio(mdio_bus), .status_reg(status_reg), .status_valid(status_valid),
        .link_up(link_up), .autoneg_done(autoneg_done),
        .read_error(read_error), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int compared = 0, mismatched = 0;

    // Monitor / PHY state
    int          cyc = 0, fc = 0, last_len = 0, init_cyc = 0, start_lat = 0;
    int          gap = 0, done_cyc = 0, sv_cnt = 0, re_cnt = 0, mdc_err = 0, chg_err = 0;
    logic [63:0] cap_o = '0, cap_oe = '0;
    logic        prev_o = 1'b1, prev_oe = 1'b0, init_prev = 1'b0;
    bit          phy_present = 0;
    logic [15:0] phy_data = '0;

    // Reference expectations
    logic [15:0] exp_status = '0;
    logic        exp_link = 1'b0, exp_aneg = 1'b0;

    always @(negedge clock) begin
        int bi, ph;
        cyc++;
        if (phy_init_done === 1'b1 && init_prev !== 1'b1) init_cyc = cyc;
        init_prev = phy_init_done;
        if (status_valid === 1'b1) sv_cnt++;
        if (read_error === 1'b1)   re_cnt++;
        if (status_valid === 1'b1 || read_error === 1'b1) done_cyc = cyc;
        if (busy === 1'b1) begin
            if (fc == 0) begin
                start_lat = cyc - init_cyc;
                gap       = cyc - done_cyc;
            end
            bi = fc / (2 * D);
            ph = fc % (2 * D);
            if (mdio_bus.mdc !== ((ph >= D) ? 1'b1 : 1'b0)) mdc_err++;
            if (ph == 0) begin
                cap_o[63 - bi]  = mdio_bus.mdio_o;
                cap_oe[63 - bi] = mdio_bus.mdio_oe;
            end else if (mdio_bus.mdio_o !== prev_o || mdio_bus.mdio_oe !== prev_oe) begin
                chg_err++;
            end
            if (!phy_present || bi <= 46) mdio_bus.mdio_i = 1'b1;
            else if (bi == 47)            mdio_bus.mdio_i = 1'b0;
            else                          mdio_bus.mdio_i = phy_data[63 - bi];
            // Data is only guaranteed around the rising mdc edge.
            if (phy_present && bi >= 46 && ph == 2 * D - 1) mdio_bus.mdio_i = 1'($urandom_range(0, 1));
            fc++;
            last_len = fc;
        end else begin
            fc = 0;
            mdio_bus.mdio_i = 1'b1;
            if (mdio_bus.mdc !== 1'b0) mdc_err++;
        end
        prev_o  = mdio_bus.mdio_o;
        prev_oe = mdio_bus.mdio_oe;
    end

    function automatic logic [23:0] outs();
        return {mdio_bus.mdc, mdio_bus.mdio_o, mdio_bus.mdio_oe, status_reg,
                status_valid, link_up, autoneg_done, read_error, busy};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name, output bit got);
        got = 0;
        for (int i = 0; i < BUDGET && !got; i++) begin
            tick();
            if (status_valid === 1'b1 || read_error === 1'b1) got = 1;
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL %s_timeout: no DONE pulse within %0d clocks", name, BUDGET);
        end
    endtask

    // One complete read frame against the PHY model.
    task automatic test_frame(input string name, input bit present, input logic [15:0] data,
                              input bit chk_lat, input bit chk_gap);
        int sv0, re0;
        bit got;
        phy_present = present;
        phy_data    = data;
        sv0 = sv_cnt; re0 = re_cnt;
        if (phy_init_done !== 1'b1) phy_init_done = 1'b1;
        wait_done(name, got);
        if (got) begin
            if (present) begin
                exp_status = data;
                exp_link   = data[BMSR_LINK];
                exp_aneg   = data[BMSR_ANEG_DONE];
            end
            compared++;
            if (status_reg !== exp_status) begin mismatched++;
                $display("FAIL %s_status: got %h want %h", name, status_reg, exp_status); end
            compared++;
            if ({link_up, autoneg_done} !== {exp_link, exp_aneg}) begin mismatched++;
                $display("FAIL %s_link_aneg: got %b%b want %b%b", name, link_up, autoneg_done, exp_link, exp_aneg); end
            compared++;
            if ({status_valid, read_error} !== (present ? 2'b10 : 2'b01)) begin mismatched++;
                $display("FAIL %s_pulse: valid/err %b%b want %b", name, status_valid, read_error, present ? 2'b10 : 2'b01); end
            compared++;
            if (last_len != FRAME_CLKS) begin mismatched++;
                $display("FAIL %s_len: frame %0d clocks want %0d", name, last_len, FRAME_CLKS); end
            compared++;
            if (cap_o[63:18] !== EXP_HDR) begin mismatched++;
                $display("FAIL %s_hdr: got %h want %h", name, cap_o[63:18], EXP_HDR); end
            compared++;
            if (cap_oe !== EXP_OE) begin mismatched++;
                $display("FAIL %s_oe: got %h want %h", name, cap_oe, EXP_OE); end
            if (chk_lat) begin
                compared++;
                if (start_lat != 1) begin mismatched++;
                    $display("FAIL %s_latency: start %0d clocks after init want 1", name, start_lat); end
            end
            if (chk_gap) begin
                compared++;
                if (gap != P) begin mismatched++;
                    $display("FAIL %s_gap: DONE to PRE %0d clocks want %0d", name, gap, P); end
            end
            tick();
            compared++;
            if ((sv_cnt - sv0) != (present ? 1 : 0) || (re_cnt - re0) != (present ? 0 : 1)) begin mismatched++;
                $display("FAIL %s_pulse_count: valid %0d err %0d want %0d %0d", name,
                         sv_cnt - sv0, re_cnt - re0, present ? 1 : 0, present ? 0 : 1); end
        end
    endtask

    task automatic wait_len(input string name, input int lo, input int hi, output bit ok);
        ok = 0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            tick();
            if (busy === 1'b1 && last_len >= lo && last_len < hi) ok = 1;
        end
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL %s_wait: frame position %0d..%0d never reached", name, lo, hi);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; phy_init_done = 1'b0;
        repeat (3) tick();
        compared++;
        if (outs() !== RST_OUTS) begin mismatched++;
            $display("FAIL reset_values: got %h want %h", outs(), RST_OUTS); end
        reset = 1'b0;
        repeat (4) tick();
        compared++;
        if (outs() !== RST_OUTS) begin mismatched++;
            $display("FAIL idle_without_init: got %h want %h", outs(), RST_OUTS); end
    endtask

    task automatic test_no_phy();
        test_frame("nophy1", 0, 16'hFFFF, 1, 0);
        test_frame("nophy2", 0, 16'hFFFF, 0, 1);
    endtask

    task automatic test_good_reads();
        test_frame("good_796d", 1, 16'h796D, 0, 1);
        test_frame("good_7949", 1, 16'h7949, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++)
            test_frame($sformatf("b2b%0d", k), $urandom_range(0, 3) != 0, 16'($urandom), 0, 1);
    endtask

    task automatic test_drop_mid_data();
        int sv0, re0;
        bit ok;
        test_frame("drop_pre", 1, 16'($urandom) | 16'h0024, 0, 1);
        phy_data = 16'($urandom);
        wait_len("drop", 50 * 2 * D, 60 * 2 * D, ok);
        if (ok) begin
            sv0 = sv_cnt; re0 = re_cnt;
            phy_init_done = 1'b0;
            tick();
            compared++;
            if ({mdio_bus.mdio_oe, busy, link_up, autoneg_done, mdio_bus.mdc} !== 5'b0) begin mismatched++;
                $display("FAIL drop_outputs: oe/busy/link/aneg/mdc %b want 00000",
                         {mdio_bus.mdio_oe, busy, link_up, autoneg_done, mdio_bus.mdc}); end
            exp_link = 1'b0; exp_aneg = 1'b0;
            repeat (8) tick();
            compared++;
            if (sv_cnt != sv0 || re_cnt != re0 || status_reg !== exp_status) begin mismatched++;
                $display("FAIL drop_quiet: valid %0d err %0d status %h want 0 0 %h",
                         sv_cnt - sv0, re_cnt - re0, status_reg, exp_status); end
        end
        test_frame("resume", 1, 16'($urandom), 1, 0);
    endtask

    task automatic test_reset_mid_hdr();
        bit ok;
        phy_data = 16'($urandom);
        wait_len("rst_hdr", 36 * 2 * D, 44 * 2 * D, ok);
        if (ok) begin
            reset = 1'b1;
            tick();
            compared++;
            if (outs() !== RST_OUTS) begin mismatched++;
                $display("FAIL reset_mid_hdr: got %h want %h", outs(), RST_OUTS); end
            exp_status = '0; exp_link = 1'b0; exp_aneg = 1'b0;
            tick();
            reset = 1'b0;
        end
        test_frame("after_reset", 1, 16'($urandom), 0, 0);
    endtask

    task automatic test_pad_timing();
        compared++;
        if (mdc_err != 0) begin mismatched++;
            $display("FAIL mdc_shape: %0d bad clocks want 0", mdc_err); end
        compared++;
        if (chg_err != 0) begin mismatched++;
            $display("FAIL mdio_change_point: %0d mid-bit changes want 0", chg_err); end
    endtask

    initial begin
        reset = 1'b1;
        phy_init_done = 1'b0;
        test_reset();
        test_no_phy();
        test_good_reads();
        test_back_to_back();
        test_drop_mid_data();
        test_reset_mid_hdr();
        test_pad_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
